// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port frame-buffer RAM between VGA scan-out reads, a write FIFO and a clear sequencer
module vga_fb_arbiter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDR_W = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vga_rd_en,
  input  logic [8:0]                  vga_line,
  input  logic [9:0]                  vga_offset,
  output logic                        pix_r,
  output logic                        pix_g,
  output logic                        pix_b,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [9:0]                  wr_x,
  input  logic [8:0]                  wr_y,
  input  logic [2:0]                  wr_color,
  output logic                        wr_err,
  input  logic                        clr_start,
  input  logic [2:0]                  clr_color,
  output logic                        clr_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [2:0]                  mem_wdata,
  input  logic [2:0]                  mem_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
  typedef enum logic [1:0] {RUN, CLR_WAIT, CLEAR} state_t;
  state_t state, state_n;
  logic [ADDR_W+2:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level_n;
  logic [ADDR_W-1:0] clr_cnt, vga_addr, wr_addr;
  logic [2:0] clr_col;
  logic vga_oob, wr_oob, accept, push, pop, clr_wr, rd_v1, rd_v2, oob1, oob2;
  assign vga_addr = (ADDR_W'(vga_line) << 9) + (ADDR_W'(vga_line) << 7) + ADDR_W'(vga_offset);
  assign wr_addr = (ADDR_W'(wr_y) << 9) + (ADDR_W'(wr_y) << 7) + ADDR_W'(wr_x);
  assign vga_oob = vga_offset >= 10'(H_RES) || vga_line >= 9'(V_RES);
  assign wr_oob = wr_x >= 10'(H_RES) || wr_y >= 9'(V_RES);
  assign accept = wr_valid && wr_ready;
  assign push = accept && !wr_oob;
  assign pop = !vga_rd_en && state != CLEAR && fifo_level != '0;
  assign clr_wr = !vga_rd_en && state == CLEAR;
  assign level_n = fifo_level + LW'(push) - LW'(pop);
  assign clr_busy = state != RUN;
  always_comb begin
    state_n = state;
    if (state == RUN && clr_start) state_n = CLR_WAIT;
    else if (state == CLR_WAIT && fifo_level == '0) state_n = CLEAR;
    else if (clr_wr && clr_cnt == LAST) state_n = RUN;
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {wr_addr, wr_color};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_level <= '0;
      wr_ready <= 1'b1;
      wr_err <= 1'b0;
      clr_cnt <= '0;
      clr_col <= '0;
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      oob1 <= 1'b0;
      oob2 <= 1'b0;
      {pix_r, pix_g, pix_b} <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      fifo_level <= level_n;
      wr_ready <= level_n != FULL && state_n != CLR_WAIT;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (accept && wr_oob) wr_err <= 1'b1;
      if (state == RUN && clr_start) clr_col <= clr_color;
      if (state == CLR_WAIT) clr_cnt <= '0;
      else if (clr_wr) clr_cnt <= clr_cnt + ADDR_W'(1);
      // read result lands two edges after the request; dummy reads return black
      rd_v1 <= vga_rd_en;
      oob1 <= vga_oob;
      rd_v2 <= rd_v1;
      oob2 <= oob1;
      if (rd_v2) {pix_r, pix_g, pix_b} <= oob2 ? 3'b000 : mem_rdata;
      mem_we <= pop || clr_wr;
      if (vga_rd_en) mem_addr <= vga_addr;
      else if (clr_wr) mem_addr <= clr_cnt;
      else if (pop) mem_addr <= fifo[rd_ptr][ADDR_W+2:3];
      if (clr_wr) mem_wdata <= clr_col;
      else if (pop) mem_wdata <= fifo[rd_ptr][2:0];
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for vga_fb_arbiter with a behavioural RAM
// A short frame (16 lines) keeps full-screen clears within a small cycle budget.
module tb_vga_fb_arbiter;
  localparam int V = 16;
  localparam int NPIX = 640 * V;
  logic clk = 0, reset = 1, vga_rd_en = 0, wr_valid = 0, clr_start = 0;
  logic [8:0] vga_line = 0, wr_y = 0;
  logic [9:0] vga_offset = 0, wr_x = 0;
  logic [2:0] wr_color = 0, clr_color = 0, mem_rdata, mem_wdata;
  logic pix_r, pix_g, pix_b, wr_ready, wr_err, clr_busy, mem_we;
  logic [2:0] fifo_level;
  logic [18:0] mem_addr;
  logic [2:0] ram [NPIX];
  logic [2:0] tb_rd;
  int checks = 0, failures = 0;
  int wq[$], rq[$], aq[$];
  int exp_mem [NPIX];
  int clr_left = 0, clr_addr = 0, clr_col = 0;

  vga_fb_arbiter #(.H_RES(640), .V_RES(V), .ADDR_W(19), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .vga_rd_en(vga_rd_en), .vga_line(vga_line), .vga_offset(vga_offset),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_err(wr_err), .clr_start(clr_start),
    .clr_color(clr_color), .clr_busy(clr_busy), .fifo_level(fifo_level), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) ram[645] <= 3'd5;
    else if (mem_we && mem_addr < 19'(NPIX)) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_addr < 19'(NPIX) ? ram[mem_addr] : 3'd0;
  end

  always @(posedge clk) begin
    if (reset) begin
      rq.delete();
      aq.delete();
    end else if (vga_rd_en) begin
      if (vga_line >= 9'(V) || vga_offset >= 10'd640) begin
        rq.push_back(0);
        aq.push_back(-1);
      end else begin
        rq.push_back(exp_mem[vga_line * 640 + vga_offset]);
        aq.push_back(vga_line * 640 + vga_offset);
      end
    end
    tb_rd <= reset ? 3'b000 : {tb_rd[1:0], vga_rd_en};
  end

  always @(negedge clk) begin
    int a, e;
    if (!reset) begin
      if (tb_rd[0]) begin
        a = aq.pop_front();
        if (a >= 0) check("rd_addr", 32'(mem_addr), a);
        check("rd_we", {31'b0, mem_we}, 0);
      end
      if (tb_rd[2]) check("pix", {29'b0, pix_r, pix_g, pix_b}, rq.pop_front());
      if (mem_we) begin
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check("wr_addr", 32'(mem_addr), e / 8);
          check("wr_data", 32'(mem_wdata), e % 8);
          exp_mem[e / 8] = e % 8;
        end else if (clr_left > 0) begin
          check("clr_addr", 32'(mem_addr), clr_addr);
          check("clr_data", 32'(mem_wdata), clr_col);
          exp_mem[clr_addr] = clr_col;
          clr_addr++;
          clr_left--;
        end else check("unexp_we", {31'b0, mem_we}, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_pix(input int line, input int off);
    vga_rd_en = 1;
    vga_line = 9'(line);
    vga_offset = 10'(off);
    @(posedge clk);
    #1 vga_rd_en = 0;
  endtask

  task automatic wr_pix(input int x, input int y, input int c);
    int n = 0;
    wr_x = 10'(x);
    wr_y = 9'(y);
    wr_color = 3'(c);
    wr_valid = 1;
    @(negedge clk);
    while (!wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wr_accept", {31'b0, wr_ready}, 1);
    if (x < 640 && y < V) wq.push_back((y * 640 + x) * 8 + c);
    @(posedge clk);
    #1 wr_valid = 0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (wq.size() == 0 && clr_left == 0) break;
    end
    check("drain", wq.size(), 0);
    check("drain_level", 32'(fifo_level), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_clear(input int c);
    clr_start = 1;
    clr_color = 3'(c);
    clr_left = NPIX;
    clr_addr = 0;
    clr_col = c;
    @(posedge clk);
    #1 clr_start = 0;
    clr_color = 3'(c ^ 7);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pix"}, {29'b0, pix_r, pix_g, pix_b}, 0);
    check({tag, "_ready"}, {31'b0, wr_ready}, 1);
    check({tag, "_err"}, {31'b0, wr_err}, 0);
    check({tag, "_busy"}, {31'b0, clr_busy}, 0);
    check({tag, "_level"}, 32'(fifo_level), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_we"}, {31'b0, mem_we}, 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
  endtask

  initial begin
    int seen, acc;
    exp_mem[645] = 5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #1 reset = 0;
    idle(1);
    // read of a preloaded pixel, then a dummy read below the frame
    rd_pix(1, 5);
    idle(3);
    @(negedge clk);
    check("pix_hold", {29'b0, pix_r, pix_g, pix_b}, 5);
    idle(1);
    rd_pix(V, 5);
    idle(3);
    // last pixel of the frame, retired within two clocks
    wr_pix(639, V - 1, 6);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_we) seen = 1;
    end
    check("wr_latency", seen, 1);
    check("level_back", 32'(fifo_level), 0);
    idle(1);
    wait_drain();
    rd_pix(V - 1, 639);
    idle(3);
    // VGA hogs every slot: FIFO fills, then drains back-to-back
    vga_rd_en = 1;
    vga_line = 0;
    vga_offset = 700;
    for (int i = 0; i < 4; i++) wr_pix(i, 2, i + 1);
    wr_x = 4;
    wr_y = 2;
    wr_color = 5;
    wr_valid = 1;
    repeat (3) begin
      @(negedge clk);
      check("full_ready", {31'b0, wr_ready}, 0);
      check("full_level", 32'(fifo_level), 4);
      check("full_we", {31'b0, mem_we}, 0);
    end
    @(posedge clk);
    #1 vga_rd_en = 0;
    @(posedge clk);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_we", {31'b0, mem_we}, 1);
      if (wr_valid && wr_ready) begin
        wq.push_back((2 * 640 + 4) * 8 + 5);
        acc = 1;
        @(posedge clk);
        #1 wr_valid = 0;
      end else @(posedge clk);
    end
    check("fifth_acc", acc, 1);
    #1;
    wait_drain();
    // out-of-range writer pixel is dropped and flagged
    wr_pix(640, 0, 1);
    @(negedge clk);
    check("err_set", {31'b0, wr_err}, 1);
    check("err_level", 32'(fifo_level), 0);
    idle(1);
    wr_pix(3, 3, 4);
    wait_drain();
    check("err_sticky", {31'b0, wr_err}, 1);
    // clear behind two buffered pixels, with scattered dummy VGA reads
    vga_rd_en = 1;
    vga_offset = 700;
    wr_pix(10, 1, 7);
    wr_pix(11, 1, 3);
    @(negedge clk);
    check("pre_clr_level", 32'(fifo_level), 2);
    @(posedge clk);
    #1 start_clear(2);
    @(negedge clk);
    check("clr_busy_set", {31'b0, clr_busy}, 1);
    check("clr_wait_ready", {31'b0, wr_ready}, 0);
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (!clr_busy) begin
        check("clr_last_we", {31'b0, mem_we}, 1);
        break;
      end
      @(posedge clk);
      #1 vga_rd_en = $urandom_range(0, 3) == 0;
      clr_start = i == 50;
      clr_color = 6;
    end
    #1;
    check("clr_done", {31'b0, clr_busy}, 0);
    check("clr_count", clr_left, 0);
    check("clr_fifo_first", wq.size(), 0);
    @(posedge clk);
    #1 vga_rd_en = 0;
    clr_start = 0;
    rd_pix(3, 7);
    rd_pix(V - 1, 639);
    idle(3);
    // reset mid-clear aborts everything
    start_clear(1);
    idle(20);
    reset = 1;
    @(posedge clk);
    #1 clr_left = 0;
    @(negedge clk);
    check_reset_vals("abort");
    @(posedge clk);
    #1 reset = 0;
    idle(2);
    @(negedge clk);
    check("abort_idle_we", {31'b0, mem_we}, 0);
    check("abort_idle_busy", {31'b0, clr_busy}, 0);
    idle(1);
    wr_pix(1, 1, 1);
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
